irq_latch16: RTL and testbench

IRQ_LATCH16 -- requirements
Module: irq_latch16

---
 rtl/irq_latch16_if.sv | 23 ++
 rtl/irq_latch16.sv | 69 ++++++
 tb/tb_irq_latch16.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/irq_latch16_if.sv
// Request/offer bus for irq_latch16: raw requests, pending vector to the external
// 16-4 priority encoder, encoder result back, and the CODE/VLD/ACK handshake.
interface irq_latch16_if;
  logic        EN;
  logic [15:0] REQ;
  logic [15:0] PEND;
  logic [3:0]  L;
  logic        GS;
  logic [3:0]  CODE;
  logic        VLD;
  logic        ACK;
  logic        OVF;

  modport master (
    output EN, REQ, L, GS, ACK,
    input  PEND, CODE, VLD, OVF
  );

  modport slave (
    input  EN, REQ, L, GS, ACK,
    output PEND, CODE, VLD, OVF
  );
endinterface

// File: rtl/irq_latch16.sv
// 16-line rising-edge interrupt latch: captures request edges into PEND and offers
// the external encoder's highest-priority index one at a time over CODE/VLD/ACK.
module irq_latch16 (
  input  logic           CP,
  input  logic           nCR,
  irq_latch16_if.slave   bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [15:0] req_d_q, req_d_d;
  logic [15:0] pend_q,  pend_d;
  logic [3:0]  code_q,  code_d;
  logic        ovf_q,   ovf_d;
  logic [0:0]  state_q, state_d;

  logic [15:0] edge_vec;
  logic [15:0] clr_vec;
  logic        xfer;

  always_comb begin
    req_d_d  = bus.REQ;
    edge_vec = bus.EN ? (bus.REQ & ~req_d_q) : '0;
    xfer     = (state_q == OFFER) && bus.ACK;
    clr_vec  = xfer ? (16'(1) << code_q) : '0;

    // A new edge overrides the clear of the same bit, so nothing is lost.
    pend_d = (pend_q & ~clr_vec) | edge_vec;
    ovf_d  = ovf_q | (|(edge_vec & pend_q & ~clr_vec));

    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (bus.GS) begin
          code_d  = bus.L;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (bus.ACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      req_d_q <= '0;
      pend_q  <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      req_d_q <= req_d_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign bus.PEND = pend_q;
  assign bus.CODE = code_q;
  assign bus.VLD  = (state_q == OFFER);
  assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_irq_latch16.sv
// Self-checking bench for irq_latch16: directed scenarios plus random traffic,
// compared against a per-bit behavioural model; the external encoder is modelled here.
module tb_irq_latch16;

  logic CP = 1'b0;
  logic nCR;
  irq_latch16_if bus();

  irq_latch16 dut (
    .CP  (CP),
    .nCR (nCR),
    .bus (bus)
  );

  always #5 CP = ~CP;

  // External 16-4 priority encoder: highest set bit wins.
  always_comb begin
    bus.L  = '0;
    bus.GS = |bus.PEND;
    for (int i = 0; i < 16; i++)
      if (bus.PEND[i]) bus.L = 4'(i);
  end

  logic [15:0] m_prev, m_pend;
  logic [3:0]  m_code;
  logic        m_vld, m_ovf;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("PEND", 32'(bus.PEND), 32'(m_pend));
    chk("VLD",  32'(bus.VLD),  32'(m_vld));
    chk("CODE", 32'(bus.CODE), 32'(m_code));
    chk("OVF",  32'(bus.OVF),  32'(m_ovf));
  endtask

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_code = '0; m_vld = 1'b0; m_ovf = 1'b0;
  endtask

  // Called just after a rising edge: drives inputs, advances model one edge, checks.
  task automatic cyc(input logic [15:0] req, input logic en, input logic ack);
    logic [15:0] np;
    logic [3:0]  nc;
    logic        nv, no;
    bit          rose, taken;
    int          top;
    bus.REQ = req; bus.EN = en; bus.ACK = ack;
    np = m_pend; nc = m_code; nv = m_vld; no = m_ovf;
    for (int i = 0; i < 16; i++) begin
      rose  = en && req[i] && !m_prev[i];
      taken = m_vld && ack && (int'(m_code) == i);
      if (rose && m_pend[i] && !taken) no = 1'b1;
      np[i] = rose || (m_pend[i] && !taken);
    end
    if (m_vld) begin
      if (ack) nv = 1'b0;
    end else begin
      top = -1;
      for (int i = 0; i < 16; i++) if (m_pend[i]) top = i;
      if (top >= 0) begin
        nc = 4'(top);
        nv = 1'b1;
      end
    end
    @(posedge CP); #1;
    m_prev = req; m_pend = np; m_code = nc; m_vld = nv; m_ovf = no;
    check_all();
  endtask

  task automatic do_reset();
    nCR = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge CP); #1;
    nCR = 1'b1;
  endtask

  logic [15:0] rq;

  initial begin
    nCR = 1'b0; bus.EN = 1'b0; bus.REQ = '0; bus.ACK = 1'b0;
    model_reset();
    @(posedge CP); #1;
    check_all();
    nCR = 1'b1;

    // Single request, held high afterwards.
    cyc(16'h0020, 1, 0);
    chk("single_pend", 32'(bus.PEND), 32'h0020);
    cyc(16'h0020, 1, 0);
    chk("single_code", 32'(bus.CODE), 32'd5);
    chk("single_vld",  32'(bus.VLD),  32'd1);
    cyc(16'h0020, 1, 1);
    chk("single_clr",  32'(bus.PEND), 32'h0000);
    for (int k = 0; k < 3; k++) cyc(16'h0020, 1, 0);
    chk("single_quiet", 32'(bus.VLD), 32'd0);

    // Offer held while a higher priority request arrives.
    cyc(16'h0008, 1, 0);
    cyc(16'h0008, 1, 0);
    cyc(16'h1008, 1, 0);
    cyc(16'h1008, 1, 0);
    chk("hold_code", 32'(bus.CODE), 32'd3);
    cyc(16'h1008, 1, 1);
    chk("hold_idle", 32'(bus.VLD), 32'd0);
    cyc(16'h1008, 1, 0);
    chk("hold_next", 32'(bus.CODE), 32'hC);
    cyc(16'h1008, 1, 1);

    // Simultaneous edges on 15 and 0.
    cyc(16'h0000, 1, 0);
    cyc(16'h8001, 1, 0);
    chk("sim_pend0", 32'(bus.PEND), 32'h8001);
    cyc(16'h8001, 1, 0);
    chk("sim_code15", 32'(bus.CODE), 32'hF);
    cyc(16'h8001, 1, 1);
    chk("sim_pend1", 32'(bus.PEND), 32'h0001);
    cyc(16'h8001, 1, 0);
    chk("sim_code0", 32'(bus.CODE), 32'h0);
    cyc(16'h8001, 1, 1);
    chk("sim_pend2", 32'(bus.PEND), 32'h0000);

    // Set wins over clear; then a genuine overflow.
    cyc(16'h0000, 1, 0);
    cyc(16'h0080, 1, 0);
    cyc(16'h0080, 1, 0);
    cyc(16'h0000, 1, 0);
    cyc(16'h0080, 1, 1);
    chk("setwin_pend", 32'(bus.PEND), 32'h0080);
    chk("setwin_ovf",  32'(bus.OVF),  32'd0);
    cyc(16'h0080, 1, 0);
    chk("setwin_reoffer", 32'(bus.CODE), 32'd7);
    cyc(16'h0000, 1, 0);
    cyc(16'h0080, 1, 0);
    chk("ovf_set", 32'(bus.OVF), 32'd1);
    for (int k = 0; k < 3; k++) cyc(16'h0080, 1, k == 0);
    chk("ovf_sticky", 32'(bus.OVF), 32'd1);

    // EN gating.
    do_reset();
    cyc(16'h0000, 0, 0);
    cyc(16'hFFFF, 0, 1);
    cyc(16'hFFFF, 0, 0);
    chk("gate_pend", 32'(bus.PEND), 32'h0000);
    chk("gate_vld",  32'(bus.VLD),  32'd0);

    // Async reset mid-offer, then a held-high line re-captured after release.
    cyc(16'h0000, 1, 0);
    cyc(16'h0400, 1, 0);
    cyc(16'h0400, 1, 0);
    chk("pre_rst_vld", 32'(bus.VLD), 32'd1);
    #2 nCR = 1'b0;
    #1;
    model_reset();
    chk("async_pend", 32'(bus.PEND), 32'h0000);
    chk("async_vld",  32'(bus.VLD),  32'd0);
    chk("async_code", 32'(bus.CODE), 32'd0);
    @(posedge CP); #1;
    nCR = 1'b1;
    cyc(16'h0400, 1, 0);
    chk("rearm_pend", 32'(bus.PEND), 32'h0400);

    // Random traffic.
    do_reset();
    rq = '0;
    for (int k = 0; k < 800; k++) begin
      rq = rq ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      cyc(rq, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
